// File: rtl/uart_fifo_if.sv
// Data-bus side of the UART: chip select, strobe, offset and data.
// The bus decoder drives master; the UART hangs off slave.
interface uart_fifo_if;
  logic        CS;
  logic        dbus_we;
  logic [3:0]  dbus_addr;
  logic [31:0] dbus_in;
  logic [31:0] dbus_out;

  modport master (
    output CS, dbus_we, dbus_addr, dbus_in,
    input  dbus_out
  );

  modport slave (
    input  CS, dbus_we, dbus_addr, dbus_in,
    output dbus_out
  );
endinterface

// File: rtl/uart_fifo.sv
// MMIO UART: programmable baud, oversampled RX, TX/RX FIFOs,
// sticky line errors and a level interrupt.
module uart_fifo #(
  parameter int DEPTH       = 8,
  parameter int OSR         = 16,
  parameter int DEFAULT_DIV = 38
) (
  input  logic       clk_in,
  input  logic       rst_in,
  uart_fifo_if.slave bus,
  input  logic       rx,
  output logic       tx,
  output logic       irq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(OSR);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] LAST = SW'(OSR - 1);
  localparam logic [SW-1:0] HALF = SW'(OSR / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } st_t;

  logic [20:0] ctrl;
  logic [15:0] bcnt;
  logic        tick;
  logic        ctrl_wr, tdr_wr, ssr_wr, rdr_rd, rd_q;
  logic [7:0]  tdr_q;
  logic        oe, pe, fe;
  logic        unused_hi;

  assign unused_hi = ^bus.dbus_in[31:21];
  assign ctrl_wr = bus.CS && bus.dbus_we && bus.dbus_addr == 4'h0;
  assign tdr_wr  = bus.CS && bus.dbus_we && bus.dbus_addr == 4'h8;
  assign ssr_wr  = bus.CS && bus.dbus_we && bus.dbus_addr == 4'hC;
  assign rdr_rd  = bus.CS && !bus.dbus_we && bus.dbus_addr == 4'h4;
  assign tick    = bcnt == ctrl[15:0];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ctrl  <= {5'b0, 16'(DEFAULT_DIV)};
      bcnt  <= '0;
      tdr_q <= '0;
      rd_q  <= 1'b0;
    end else begin
      if (ctrl_wr) ctrl <= bus.dbus_in[20:0];
      bcnt <= (ctrl_wr || tick) ? '0 : bcnt + 16'd1;
      if (tdr_wr) tdr_q <= bus.dbus_in[7:0];
      rd_q <= rdr_rd;
    end
  end

  // TX FIFO
  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [CW-1:0] tx_cnt;
  logic          tx_full, tx_empty, tx_push, tx_pop;

  assign tx_full  = tx_cnt == FULL;
  assign tx_empty = tx_cnt == '0;
  assign tx_push  = tdr_wr && (!tx_full || tx_pop);

  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wp] <= bus.dbus_in[7:0];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      tx_cnt <= tx_cnt + CW'(tx_push) - CW'(tx_pop);
    end
  end

  // TX FSM
  st_t         tx_st, tx_st_n;
  logic [SW-1:0] tx_sub;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_sh;
  logic        tx_pen, tx_odd, tx_adv;

  assign tx_adv = tick && tx_sub == LAST;

  always_comb begin
    tx_st_n = tx_st;
    tx_pop  = 1'b0;
    unique case (tx_st)
      S_IDLE:
        if (tick && !tx_empty) begin
          tx_st_n = S_START;
          tx_pop  = 1'b1;
        end
      S_START: if (tx_adv) tx_st_n = S_DATA;
      S_DATA:
        if (tx_adv && tx_idx == 3'd7)
          tx_st_n = tx_pen ? S_PAR : S_STOP;
      S_PAR: if (tx_adv) tx_st_n = S_STOP;
      S_STOP:
        if (tx_adv) begin
          tx_st_n = tx_empty ? S_IDLE : S_START;
          tx_pop  = !tx_empty;
        end
      default: tx_st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tx_st  <= S_IDLE;
      tx_sub <= '0;
      tx_idx <= '0;
      tx_sh  <= '0;
      tx_pen <= 1'b0;
      tx_odd <= 1'b0;
    end else begin
      tx_st <= tx_st_n;
      if (tx_pop) begin
        tx_sh  <= tx_mem[tx_rp];
        tx_pen <= ctrl[19];
        tx_odd <= ctrl[20];
        tx_sub <= '0;
        tx_idx <= '0;
      end else if (tick && tx_st != S_IDLE) begin
        tx_sub <= tx_adv ? '0 : tx_sub + 1'b1;
        if (tx_adv && tx_st == S_DATA) tx_idx <= tx_idx + 3'd1;
      end
    end
  end

  always_comb begin
    tx = 1'b1;
    unique case (tx_st)
      S_START: tx = 1'b0;
      S_DATA:  tx = tx_sh[tx_idx];
      S_PAR:   tx = ^tx_sh ^ tx_odd;
      default: tx = 1'b1;
    endcase
  end

  // RX synchroniser, FIFO and FSM
  logic          rx_s1, rx_s2, rx_prev, rx_fall;
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [CW-1:0] rx_cnt;
  logic          rx_full, rx_empty, rx_push, rx_pop;
  st_t           rx_st, rx_st_n;
  logic [SW-1:0] rx_sub;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_sh;
  logic          rx_pen, rx_odd, rx_pbit, rx_done;
  logic          rx_adv, rx_mid, stop_bad, par_bad;

  assign rx_fall  = rx_prev && !rx_s2;
  assign rx_adv   = tick && rx_sub == LAST;
  assign rx_mid   = tick && rx_sub == HALF;
  assign rx_full  = rx_cnt == FULL;
  assign rx_empty = rx_cnt == '0;
  assign rx_pop   = rdr_rd && !rd_q && !rx_empty;
  assign stop_bad = !rx_s2;
  assign par_bad  = rx_pen && (rx_pbit != (^rx_sh ^ rx_odd));
  assign rx_push  = rx_done && !stop_bad && !par_bad
                    && (!rx_full || rx_pop);

  always_comb begin
    rx_st_n = rx_st;
    rx_done = 1'b0;
    unique case (rx_st)
      S_IDLE:  if (rx_fall) rx_st_n = S_START;
      S_START: if (rx_mid) rx_st_n = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:
        if (rx_adv && rx_idx == 3'd7)
          rx_st_n = rx_pen ? S_PAR : S_STOP;
      S_PAR: if (rx_adv) rx_st_n = S_STOP;
      S_STOP:
        if (rx_adv) begin
          rx_st_n = S_IDLE;
          rx_done = 1'b1;
        end
      default: rx_st_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wp] <= rx_sh;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= S_IDLE;
      rx_sub  <= '0;
      rx_idx  <= '0;
      rx_sh   <= '0;
      rx_pen  <= 1'b0;
      rx_odd  <= 1'b0;
      rx_pbit <= 1'b0;
      rx_wp   <= '0;
      rx_rp   <= '0;
      rx_cnt  <= '0;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_st   <= rx_st_n;
      if (rx_st == S_IDLE) begin
        if (rx_fall) begin
          rx_sub <= '0;
          rx_idx <= '0;
          rx_pen <= ctrl[19];
          rx_odd <= ctrl[20];
        end
      end else if (tick) begin
        // start bit counts to its midpoint, later bits a full period
        if (rx_st == S_START) rx_sub <= rx_mid ? '0 : rx_sub + 1'b1;
        else rx_sub <= rx_adv ? '0 : rx_sub + 1'b1;
        if (rx_adv && rx_st == S_DATA) begin
          rx_sh  <= {rx_s2, rx_sh[7:1]};
          rx_idx <= rx_idx + 3'd1;
        end
        if (rx_adv && rx_st == S_PAR) rx_pbit <= rx_s2;
      end
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
    end
  end

  // Sticky errors: a new set beats a same-cycle clear
  logic set_fe, set_pe, set_oe;
  assign set_fe = rx_done && stop_bad;
  assign set_pe = rx_done && !stop_bad && par_bad;
  assign set_oe = rx_done && !stop_bad && !par_bad
                  && rx_full && !rx_pop;

  logic       tx_idle;
  logic [8:0] ssr;
  assign tx_idle = tx_empty && tx_st == S_IDLE;
  assign ssr = {fe, pe, oe, rx_full, tx_idle, tx_st != S_IDLE,
                rx_st != S_IDLE, !rx_empty, !tx_full};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      oe  <= 1'b0;
      pe  <= 1'b0;
      fe  <= 1'b0;
      irq <= 1'b0;
    end else begin
      oe  <= set_oe | (oe & !(ssr_wr & bus.dbus_in[6]));
      pe  <= set_pe | (pe & !(ssr_wr & bus.dbus_in[7]));
      fe  <= set_fe | (fe & !(ssr_wr & bus.dbus_in[8]));
      irq <= (ctrl[16] & !rx_empty) | (ctrl[17] & tx_idle)
             | (ctrl[18] & (oe | pe | fe));
    end
  end

  always_comb begin
    bus.dbus_out = '0;
    if (bus.CS) begin
      case (bus.dbus_addr)
        4'h0: bus.dbus_out = {11'b0, ctrl};
        4'h4: bus.dbus_out = rx_empty ? '0 : {24'b0, rx_mem[rx_rp]};
        4'h8: bus.dbus_out = {24'b0, tdr_q};
        4'hC: bus.dbus_out = {23'b0, ssr};
        default: bus.dbus_out = '0;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_fifo.sv
// Bench for uart_fifo: bus tasks, serial driver and TX decoder
// feeding byte scoreboards.
module tb_uart_fifo;
  localparam int DEPTH = 8;
  localparam int BIT   = 16;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rx = 1'b1;
  logic tx, irq;

  uart_fifo_if bus();

  uart_fifo #(
    .DEPTH(DEPTH), .OSR(16), .DEFAULT_DIV(38)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus(bus),
    .rx(rx),
    .tx(tx),
    .irq(irq)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;
  int tx_frames = 0;
  bit mon_en = 1'b0;
  logic [7:0] txq[$];
  logic [7:0] rxq[$];
  logic [31:0] rd;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk_in);
    bus.CS = 1'b1; bus.dbus_we = 1'b1;
    bus.dbus_addr = a; bus.dbus_in = d;
    @(negedge clk_in);
    bus.CS = 1'b0; bus.dbus_we = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk_in);
    bus.CS = 1'b1; bus.dbus_we = 1'b0; bus.dbus_addr = a;
    #1 d = bus.dbus_out;
    @(negedge clk_in);
    bus.CS = 1'b0;
  endtask

  task automatic rx_bit(input logic v);
    rx = v;
    repeat (BIT) @(negedge clk_in);
  endtask

  task automatic send_rx(input logic [7:0] d, input bit pen,
                         input bit pbit, input bit stopb);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(d[i]);
    if (pen) rx_bit(pbit);
    rx_bit(stopb);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk_in);
  endtask

  // Serial TX decoder, 8N1 at one tick per clock
  initial begin : tx_mon
    logic [7:0] b;
    logic s0, sp;
    forever begin
      @(negedge tx);
      if (mon_en) begin
        repeat (BIT / 2) @(negedge clk_in);
        s0 = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk_in);
          b[i] = tx;
        end
        repeat (BIT) @(negedge clk_in);
        sp = tx;
        chk("tx_start", {31'b0, s0}, 32'h0);
        chk("tx_stop", {31'b0, sp}, 32'h1);
        if (txq.size() == 0) chk("tx_extra", {24'b0, b}, 32'hFFFF_FFFF);
        else chk("tx_byte", {24'b0, b}, {24'b0, txq.pop_front()});
        tx_frames++;
      end
    end
  end

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus.CS = 1'b0; bus.dbus_we = 1'b0;
    bus.dbus_addr = '0; bus.dbus_in = '0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;

    bus_rd(4'hC, rd); chk("rst_ssr", rd, 32'h011);
    bus_rd(4'h0, rd); chk("rst_ctrl", rd, 32'h26);
    chk("rst_tx", {31'b0, tx}, 32'h1);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    mon_en = 1'b1;

    // single frame at DIV=0
    bus_wr(4'h0, 32'h0);
    txq.push_back(8'h55);
    bus_wr(4'h8, 32'h55);
    bus_rd(4'hC, rd); chk("tx_busy", {31'b0, rd[3]}, 32'h1);
    for (int c = 0; c < 400 && tx_frames < 1; c++) @(negedge clk_in);
    chk("tx_frames1", tx_frames, 1);
    repeat (20) @(negedge clk_in);
    bus_rd(4'hC, rd); chk("tx_idle", rd, 32'h011);
    bus_wr(4'h0, 32'h2_0000);
    repeat (2) @(negedge clk_in);
    chk("irq_tx", {31'b0, irq}, 32'h1);
    bus_wr(4'h0, 32'h0);

    // overflow: one byte in flight plus DEPTH queued, the rest dropped
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (i <= DEPTH) txq.push_back(8'(8'h10 + i));
      bus_wr(4'h8, 32'(8'h10 + i));
      if (i == DEPTH) begin
        bus_rd(4'hC, rd); chk("tx_full_ssr", rd, 32'h008);
      end
    end
    bus_rd(4'h8, rd); chk("tdr_rb", rd, 32'(8'h10 + DEPTH + 1));
    for (int c = 0; c < 3000 && tx_frames < DEPTH + 2; c++)
      @(negedge clk_in);
    chk("tx_frames", tx_frames, DEPTH + 2);
    chk("txq_left", txq.size(), 0);
    repeat (20) @(negedge clk_in);

    // receive with ie_rx, held read pops once
    bus_wr(4'h0, 32'h1_0000);
    rxq.push_back(8'hA3); send_rx(8'hA3, 0, 0, 1);
    rxq.push_back(8'h5C); send_rx(8'h5C, 0, 0, 1);
    bus_rd(4'hC, rd); chk("rx_ssr", rd, 32'h013);
    chk("irq_rx", {31'b0, irq}, 32'h1);
    @(negedge clk_in);
    bus.CS = 1'b1; bus.dbus_we = 1'b0; bus.dbus_addr = 4'h4;
    #1 chk("rdr_held", bus.dbus_out, {24'b0, rxq.pop_front()});
    repeat (3) @(negedge clk_in);
    bus.CS = 1'b0;
    bus_rd(4'hC, rd); chk("rx_ssr_one", rd, 32'h013);
    bus_rd(4'h4, rd); chk("rdr2", rd, {24'b0, rxq.pop_front()});
    bus_rd(4'hC, rd); chk("rx_ssr_empty", rd, 32'h011);
    bus_rd(4'h4, rd); chk("rdr_empty", rd, 32'h0);
    repeat (2) @(negedge clk_in);
    chk("irq_rx_off", {31'b0, irq}, 32'h0);

    // parity / framing errors
    bus_wr(4'h0, 32'hC_0000);
    send_rx(8'h07, 1, 0, 1);
    bus_rd(4'hC, rd); chk("pe_set", rd, 32'h091);
    chk("irq_err", {31'b0, irq}, 32'h1);
    send_rx(8'h07, 1, 1, 0);
    bus_rd(4'hC, rd); chk("fe_set", rd, 32'h191);
    bus_wr(4'hC, 32'h1C0);
    repeat (2) @(negedge clk_in);
    bus_rd(4'hC, rd); chk("err_clr", rd, 32'h011);
    chk("irq_err_off", {31'b0, irq}, 32'h0);
    bus_wr(4'h0, 32'h18_0000);
    rxq.push_back(8'h07); send_rx(8'h07, 1, 0, 1);
    bus_rd(4'h4, rd); chk("rdr_odd", rd, {24'b0, rxq.pop_front()});

    // overrun
    bus_wr(4'h0, 32'h0);
    for (int i = 0; i <= DEPTH; i++) begin
      if (i < DEPTH) rxq.push_back(8'(8'h30 + i));
      send_rx(8'(8'h30 + i), 0, 0, 1);
    end
    bus_rd(4'hC, rd); chk("oe_ssr", rd, 32'h073);
    for (int i = 0; i < DEPTH; i++) begin
      bus_rd(4'h4, rd); chk("rdr_fill", rd, {24'b0, rxq.pop_front()});
    end
    bus_rd(4'hC, rd); chk("oe_sticky", rd, 32'h051);
    bus_wr(4'hC, 32'h1C0);

    // short glitch on rx
    @(negedge clk_in); rx = 1'b0;
    @(negedge clk_in); rx = 1'b1;
    repeat (40) @(negedge clk_in);
    bus_rd(4'hC, rd); chk("glitch", rd, 32'h011);

    // reset mid-frame
    mon_en = 1'b0;
    bus_wr(4'h8, 32'hF0);
    repeat (40) @(negedge clk_in);
    chk("tx_mid", {31'b0, tx}, 32'h0);
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("tx_rst", {31'b0, tx}, 32'h1);
    rst_in = 1'b0;
    bus_rd(4'hC, rd); chk("rst2_ssr", rd, 32'h011);
    bus_rd(4'h0, rd); chk("rst2_ctrl", rd, 32'h26);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
